lpif_tx_packer: RTL and testbench
=================================

// Module: lpif_tx_packer
// PURPOSE
//  Upstream neighbour of the PHY TX top: accepts the link layer's 32-bit TLP/DLLP beat stream and packs it into
//  the 512-bit LPIF word (lp_data/lp_valid, per-byte start/end markers, lp_irdy) consumed by TX_CONTROL.
//  Double-buffered (accumulator + output register), so input keeps flowing while one word waits on back-pressure.
// PARAMETERS
//  IN_BYTES    4   bytes per input beat; must divide OUT_BYTES
//  OUT_BYTES   64  bytes per LPIF word (lp_data = 8*OUT_BYTES bits)
//  IDLE_FLUSH  8   idle cycles with a partial word before it is flushed; 1..255
// PORTS
//  pclk         in   1     clock
//  reset_n      in   1     synchronous active-low reset
//  in_data      in   32    beat; byte k = in_data[8k+7:8k], byte 0 first on the wire
//  in_valid     in   1     beat valid
//  in_ready     out  1     beat accepted when in_valid && in_ready
//  in_sop       in   1     first beat of packet
//  in_eop       in   1     last beat of packet
//  in_nbytes    in   3     valid bytes on eop beat, 1..4 from byte 0 (ignored, taken as 4, when !in_eop)
//  in_dllp      in   1     packet is a DLLP (sampled on sop beat); 0 = TLP
//  flush        in   1     force emission of a partial word
//  pl_trdy      in   1     TX FIFO full: word is NOT taken while high
//  lp_irdy      out  1     output word valid
//  lp_data      out  512   packed bytes; byte j = lp_data[8j+7:8j]
//  lp_valid     out  64    per-byte valid
//  lp_tlpstart / lp_tlpend / lp_dlpstart / lp_dlpend  out  64 each  per-byte markers
//  proto_err    out  1     one-cycle pulse on framing violation
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; ptr=0, accumulator and output register cleared, idle counter 0.
//   Reset mid-word discards all buffered data; no partial word is emitted.
//  Accept: byte k -> accumulator byte ptr+k, valid bit set; ptr += n (n = in_nbytes on eop, else 4).
//   sop sets start bit (tlp/dlp per in_dllp) at byte ptr; eop sets end bit at ptr+n-1.
//   After eop, ptr rounds up to the next multiple of 4; pad bytes keep valid=0, data=0.
//  Word complete when ptr reaches 64, on flush with ptr!=0, or when idle count hits IDLE_FLUSH with ptr!=0.
//   Completion sets acc_full (registered); in_ready = !acc_full. flush/idle with ptr==0: no action.
//  Idle counter: cleared on every accepted beat; increments each cycle with no accepted beat while ptr!=0;
//   saturates at IDLE_FLUSH; cleared when the accumulator is handed off.
//  Handoff: acc_full && (!lp_irdy || out_taken) -> output register loads, accumulator clears, ptr=0, acc_full=0.
//   out_taken = lp_irdy && !pl_trdy. The simultaneous take-and-load gives zero bubble.
//  Output: lp_irdy and all lp_* change only on handoff/take; they are held stable while lp_irdy && pl_trdy.
//   On take with no pending handoff: lp_irdy->0, lp_* -> 0.
//  Latency: beat completing a word accepted at edge t -> acc_full after t -> lp_irdy high after edge t+1
//   (output register free).
//  Framing: tracks in_packet. proto_err pulses (the cycle after acceptance) for sop while in_packet, or for a
//   non-sop beat while !in_packet. The beat is still packed; sop restarts the packet.
//   Single-beat packet (sop && eop) is legal.
//  Back-pressure: pl_trdy high indefinitely -> one word in output, one in accumulator, in_ready=0; no data lost.
// TESTING
//  1 Reset: after reset_n low 1 cycle -> in_ready=1, lp_irdy=0, lp_valid=0, proto_err=0.
//  2 16 TLP beats 0x03020100..0x3F3E3D3C (sop first, eop last, nbytes=4), pl_trdy=0
//    -> lp_irdy 1 cycle after edge t+1; lp_valid=all 1; byte j=j; tlpstart bit0, tlpend bit63.
//  3 DLLP 2 beats, eop nbytes=2, then idle -> after 8 idle cycles word emitted:
//    lp_valid=0x3F, dlpstart bit0, dlpend bit5.
//  4 Unaligned restart: 3-byte TLP then sop of next TLP -> next tlpstart at byte 4, byte 3 valid=0.
//  5 pl_trdy held 1 while streaming 40 beats -> in_ready drops after 32 accepted.
//    Release -> two words delivered in order, no loss or duplication.
//  6 Reset asserted with ptr=20 and lp_irdy=1 -> next cycle lp_irdy=0, ptr=0.
//    Subsequent sop lands at byte 0.
//  7 Beat without sop after eop -> proto_err pulses once.
//    flush with ptr!=0 emits next cycle.

Source files
------------

// File: rtl/lpif_tx_packer.sv
// Packs the link layer's 32-bit TLP/DLLP beat stream into 512-bit LPIF words.
// Double-buffered: an accumulator fills while the output register waits on pl_trdy.
module lpif_tx_packer #(
    parameter int IN_BYTES   = 4,
    parameter int OUT_BYTES  = 64,
    parameter int IDLE_FLUSH = 8
) (
    input  logic                   pclk,
    input  logic                   reset_n,
    input  logic [8*IN_BYTES-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [2:0]             in_nbytes,
    input  logic                   in_dllp,
    input  logic                   flush,
    input  logic                   pl_trdy,
    output logic                   lp_irdy,
    output logic [8*OUT_BYTES-1:0] lp_data,
    output logic [OUT_BYTES-1:0]   lp_valid,
    output logic [OUT_BYTES-1:0]   lp_tlpstart,
    output logic [OUT_BYTES-1:0]   lp_tlpend,
    output logic [OUT_BYTES-1:0]   lp_dlpstart,
    output logic [OUT_BYTES-1:0]   lp_dlpend,
    output logic                   proto_err
);

    localparam int IDX_W = $clog2(OUT_BYTES);
    localparam int PTR_W = $clog2(OUT_BYTES + 1);

    logic [8*OUT_BYTES-1:0] acc_data, data_nxt;
    logic [OUT_BYTES-1:0]   acc_valid, valid_nxt;
    logic [OUT_BYTES-1:0]   acc_tlps, tlps_nxt, acc_tlpe, tlpe_nxt;
    logic [OUT_BYTES-1:0]   acc_dlps, dlps_nxt, acc_dlpe, dlpe_nxt;
    logic [PTR_W-1:0]       ptr, ptr_nxt;
    logic                   acc_full;
    logic [7:0]             idle_cnt;
    logic                   in_packet, pkt_dllp;
    logic                   accept, out_taken, handoff, end_dllp;
    logic [2:0]             beat_n;
    logic [IDX_W-1:0]       base, end_idx;

    assign in_ready  = !acc_full;
    assign accept    = in_valid && !acc_full;
    assign out_taken = lp_irdy && !pl_trdy;
    assign handoff   = acc_full && (!lp_irdy || out_taken);

    // Out-of-range byte counts on an eop beat are treated as a full beat.
    assign beat_n   = (in_eop && in_nbytes != 3'd0 && in_nbytes < 3'(IN_BYTES)) ? in_nbytes : 3'(IN_BYTES);
    assign base     = ptr[IDX_W-1:0];
    assign end_idx  = base + IDX_W'(beat_n) - IDX_W'(1);
    assign end_dllp = in_sop ? in_dllp : pkt_dllp;
    // ptr is always beat aligned: a short eop beat rounds up to the same step as a full one.
    assign ptr_nxt  = ptr + PTR_W'(IN_BYTES);

    always_comb begin
        data_nxt  = acc_data;
        valid_nxt = acc_valid;
        tlps_nxt  = acc_tlps;
        tlpe_nxt  = acc_tlpe;
        dlps_nxt  = acc_dlps;
        dlpe_nxt  = acc_dlpe;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (3'(k) < beat_n) begin
                data_nxt[{base + IDX_W'(k), 3'b000} +: 8] = in_data[8*k +: 8];
                valid_nxt[base + IDX_W'(k)]              = 1'b1;
            end
        end
        if (in_sop) begin
            if (in_dllp) dlps_nxt[base] = 1'b1;
            else         tlps_nxt[base] = 1'b1;
        end
        if (in_eop) begin
            if (end_dllp) dlpe_nxt[end_idx] = 1'b1;
            else          tlpe_nxt[end_idx] = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n || handoff) begin
            acc_data  <= '0;
            acc_valid <= '0;
            acc_tlps  <= '0;
            acc_tlpe  <= '0;
            acc_dlps  <= '0;
            acc_dlpe  <= '0;
            ptr       <= '0;
            acc_full  <= 1'b0;
            idle_cnt  <= '0;
        end else if (!acc_full) begin
            if (accept) begin
                acc_data  <= data_nxt;
                acc_valid <= valid_nxt;
                acc_tlps  <= tlps_nxt;
                acc_tlpe  <= tlpe_nxt;
                acc_dlps  <= dlps_nxt;
                acc_dlpe  <= dlpe_nxt;
                ptr       <= ptr_nxt;
                idle_cnt  <= '0;
                acc_full  <= (ptr_nxt == PTR_W'(OUT_BYTES)) || flush;
            end else if (ptr != '0) begin
                if (idle_cnt != 8'(IDLE_FLUSH))
                    idle_cnt <= idle_cnt + 8'd1;
                if (flush || idle_cnt == 8'(IDLE_FLUSH - 1))
                    acc_full <= 1'b1;
            end
        end
    end

    // A take and a handoff in the same cycle reload the output with no bubble.
    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            lp_irdy     <= 1'b0;
            lp_data     <= '0;
            lp_valid    <= '0;
            lp_tlpstart <= '0;
            lp_tlpend   <= '0;
            lp_dlpstart <= '0;
            lp_dlpend   <= '0;
        end else if (handoff) begin
            lp_irdy     <= 1'b1;
            lp_data     <= acc_data;
            lp_valid    <= acc_valid;
            lp_tlpstart <= acc_tlps;
            lp_tlpend   <= acc_tlpe;
            lp_dlpstart <= acc_dlps;
            lp_dlpend   <= acc_dlpe;
        end else if (out_taken) begin
            lp_irdy     <= 1'b0;
            lp_data     <= '0;
            lp_valid    <= '0;
            lp_tlpstart <= '0;
            lp_tlpend   <= '0;
            lp_dlpstart <= '0;
            lp_dlpend   <= '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            in_packet <= 1'b0;
            pkt_dllp  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= accept && (in_sop ? in_packet : !in_packet);
            if (accept) begin
                in_packet <= !in_eop;
                if (in_sop) pkt_dllp <= in_dllp;
            end
        end
    end

endmodule

// File: tb/tb_lpif_tx_packer.sv
// Directed and randomized checks of lpif_tx_packer against a byte-level packing model.
module tb_lpif_tx_packer;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  v;
        logic [63:0]  ts;
        logic [63:0]  te;
        logic [63:0]  ds;
        logic [63:0]  de;
    } word_t;

    logic         pclk = 1'b0;
    logic         reset_n;
    logic [31:0]  in_data;
    logic         in_valid, in_ready, in_sop, in_eop, in_dllp, flush, pl_trdy;
    logic [2:0]   in_nbytes;
    logic         lp_irdy, proto_err;
    logic [511:0] lp_data;
    logic [63:0]  lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;
    word_t        lp_word;

    int tests_run = 0;
    int failed = 0;

    word_t exp_q[$];
    word_t got_q[$];
    logic [511:0] m_d;
    logic [63:0]  m_v, m_ts, m_te, m_ds, m_de;
    int  m_ptr;
    bit  m_inpkt, m_dllp;
    int  exp_err = 0;
    int  got_err = 0;
    bit  rand_bp = 0;
    bit  hold_prev = 0;
    word_t hold_word;

    lpif_tx_packer dut (
        .pclk(pclk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_eop(in_eop), .in_nbytes(in_nbytes), .in_dllp(in_dllp), .flush(flush),
        .pl_trdy(pl_trdy), .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid),
        .lp_tlpstart(lp_tlpstart), .lp_tlpend(lp_tlpend), .lp_dlpstart(lp_dlpstart),
        .lp_dlpend(lp_dlpend), .proto_err(proto_err)
    );

    always #5 pclk = ~pclk;

    assign lp_word = {lp_data, lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend};

    task automatic chk(input string tag, input logic [831:0] obs, input logic [831:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Words are captured when they are actually taken, and must not move while stalled.
    always @(negedge pclk) begin
        if (reset_n && proto_err) got_err++;
        if (reset_n && lp_irdy && !pl_trdy) got_q.push_back(lp_word);
        if (reset_n && hold_prev) chk("hold_stable", lp_word, hold_word);
        hold_prev = reset_n && lp_irdy && pl_trdy;
        hold_word = lp_word;
    end

    task automatic modelClear();
        m_d = '0; m_v = '0; m_ts = '0; m_te = '0; m_ds = '0; m_de = '0;
        m_ptr = 0;
    endtask

    task automatic modelClose();
        if (m_ptr != 0) begin
            exp_q.push_back({m_d, m_v, m_ts, m_te, m_ds, m_de});
            modelClear();
        end
    endtask

    task automatic modelAccept(input logic [31:0] data, input bit sop, input bit eop, input int nb, input bit dllp);
        int n;
        n = eop ? nb : 4;
        if (sop ? m_inpkt : !m_inpkt) exp_err++;
        m_inpkt = !eop;
        if (sop) begin
            m_dllp = dllp;
            if (dllp) m_ds[m_ptr] = 1'b1;
            else      m_ts[m_ptr] = 1'b1;
        end
        for (int k = 0; k < n; k++) begin
            m_d[8*(m_ptr+k) +: 8] = data[8*k +: 8];
            m_v[m_ptr+k] = 1'b1;
        end
        if (eop) begin
            if (m_dllp) m_de[m_ptr+n-1] = 1'b1;
            else        m_te[m_ptr+n-1] = 1'b1;
        end
        m_ptr = m_ptr + n;
        if (eop) m_ptr = ((m_ptr + 3) / 4) * 4;
        if (m_ptr == 64) modelClose();
    endtask

    task automatic tryBeat(input logic [31:0] data, input bit sop, input bit eop, input int nb,
                           input bit dllp, output bit acc);
        bit rdy;
        in_valid = 1'b1; in_data = data; in_sop = sop; in_eop = eop;
        in_nbytes = 3'(nb); in_dllp = dllp;
        if (rand_bp) pl_trdy = 1'($urandom_range(0, 1));
        rdy = in_ready;
        @(posedge pclk); #1;
        acc = rdy;
        if (rdy) modelAccept(data, sop, eop, nb, dllp);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input bit sop, input bit eop, input int nb, input bit dllp);
        bit a = 0;
        for (int c = 0; c < 300 && !a; c++) tryBeat(data, sop, eop, nb, dllp, a);
        chk("beat_accepted", a, 1);
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            if (rand_bp) pl_trdy = 1'($urandom_range(0, 1));
            @(posedge pclk); #1;
        end
    endtask

    task automatic doFlush();
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge pclk); #1;
        flush = 1'b0;
        modelClose();
    endtask

    task automatic waitIrdy(input int maxc);
        for (int c = 0; c < maxc && !lp_irdy; c++) begin
            @(posedge pclk); #1;
        end
        chk("irdy_within_bound", lp_irdy, 1);
    endtask

    task automatic checkOutput(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] seq_bytes;
        int  accepted, stall, nbeats;
        bit  a, dllp, eop;

        in_valid = 0; in_data = '0; in_sop = 0; in_eop = 0; in_nbytes = 3'd4; in_dllp = 0;
        flush = 0; pl_trdy = 0; reset_n = 0;
        modelClear(); m_inpkt = 0;

        // Reset values
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_lp_irdy", lp_irdy, 0);
        chk("rst_lp_valid", lp_valid, 0);
        chk("rst_proto_err", proto_err, 0);
        reset_n = 1;

        // Full aligned TLP word with incrementing bytes
        for (int i = 0; i < 16; i++)
            applyStimulus({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, i == 0, i == 15, 4, 0);
        chk("t2_irdy_at_t", lp_irdy, 0);
        chk("t2_ready_full", in_ready, 0);
        @(posedge pclk); #1;
        chk("t2_irdy_t1", lp_irdy, 1);
        chk("t2_valid", lp_valid, {64{1'b1}});
        for (int j = 0; j < 64; j++) seq_bytes[8*j +: 8] = 8'(j);
        chk("t2_data", lp_data, seq_bytes);
        chk("t2_tlpstart", lp_tlpstart, 64'h1);
        chk("t2_tlpend", lp_tlpend, 64'h8000_0000_0000_0000);
        idleCycles(2);
        checkOutput("t2");

        // Short DLLP flushed by idle timeout
        applyStimulus($urandom(), 1, 0, 4, 1);
        applyStimulus($urandom(), 0, 1, 2, 1);
        modelClose();
        idleCycles(7);
        chk("t3_no_early_flush", lp_irdy, 0);
        waitIrdy(4);
        chk("t3_valid", lp_valid, 64'h3F);
        chk("t3_dlpstart", lp_dlpstart, 64'h1);
        chk("t3_dlpend", lp_dlpend, 64'h20);
        idleCycles(2);
        checkOutput("t3");

        // 3-byte TLP followed by a new TLP: next start realigns to byte 4
        applyStimulus($urandom(), 1, 1, 3, 0);
        applyStimulus($urandom(), 1, 0, 4, 0);
        applyStimulus($urandom(), 0, 1, 4, 0);
        doFlush();
        @(posedge pclk); #1;
        chk("t4_flush_emit", lp_irdy, 1);
        chk("t4_valid", lp_valid, 64'hFF7);
        chk("t4_tlpstart", lp_tlpstart, 64'h11);
        chk("t4_tlpend", lp_tlpend, 64'h804);
        idleCycles(2);
        checkOutput("t4");

        // Sustained back-pressure: one word out, one in the accumulator, then stall
        pl_trdy = 1;
        accepted = 0; stall = 0;
        for (int c = 0; c < 200 && accepted < 40 && stall < 6; c++) begin
            tryBeat($urandom(), accepted == 0, accepted == 39, 4, 0, a);
            if (a) begin accepted++; stall = 0; end
            else stall++;
        end
        chk("t5_accepted_before_stall", accepted, 32);
        chk("t5_in_ready_low", in_ready, 0);
        chk("t5_irdy_held", lp_irdy, 1);
        pl_trdy = 0;
        for (int i = accepted; i < 40; i++) applyStimulus($urandom(), 0, i == 39, 4, 0);
        doFlush();
        idleCycles(6);
        checkOutput("t5");

        // Reset with a word waiting and a partial accumulator
        pl_trdy = 1;
        for (int i = 0; i < 16; i++) applyStimulus($urandom(), i == 0, i == 15, 4, 0);
        for (int i = 0; i < 5; i++) applyStimulus($urandom(), i == 0, 0, 4, 0);
        chk("t6_pre_irdy", lp_irdy, 1);
        reset_n = 0;
        @(posedge pclk); #1;
        chk("t6_rst_irdy", lp_irdy, 0);
        chk("t6_rst_ready", in_ready, 1);
        reset_n = 1; pl_trdy = 0;
        exp_q.delete(); got_q.delete(); modelClear(); m_inpkt = 0;
        applyStimulus($urandom(), 1, 1, 4, 0);
        doFlush();
        @(posedge pclk); #1;
        chk("t6_tlpstart_byte0", lp_tlpstart, 64'h1);
        chk("t6_valid", lp_valid, 64'hF);
        idleCycles(2);
        checkOutput("t6");

        // Framing error on a beat without sop, flush on empty accumulator does nothing
        applyStimulus($urandom(), 0, 1, 4, 0);
        chk("t7_proto_pulse", proto_err, 1);
        @(posedge pclk); #1;
        chk("t7_proto_once", proto_err, 0);
        doFlush();
        @(posedge pclk); #1;
        chk("t7_flush_emit", lp_irdy, 1);
        idleCycles(2);
        doFlush();
        idleCycles(3);
        chk("t7_empty_flush_idle", lp_irdy, 0);
        checkOutput("t7");

        // Random packets with random back-pressure and short gaps
        rand_bp = 1;
        for (int p = 0; p < 40; p++) begin
            nbeats = $urandom_range(1, 6);
            dllp = 1'($urandom_range(0, 1));
            for (int b = 0; b < nbeats; b++) begin
                eop = (b == nbeats - 1);
                applyStimulus($urandom(), b == 0, eop, eop ? $urandom_range(1, 4) : 4, dllp);
                if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
            end
        end
        rand_bp = 0; pl_trdy = 0;
        doFlush();
        idleCycles(8);
        checkOutput("rand");
        chk("proto_err_count", got_err, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
